// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - request/result bundle between the execute stage and mult_div
interface mult_div_if #(parameter int n = 32);
  logic         Start;
  logic [2:0]   Op;
  logic [n-1:0] BusA;
  logic [n-1:0] BusB;
  logic         Busy;
  logic         Done;
  logic [n-1:0] HI;
  logic [n-1:0] LO;

  modport master (output Start, Op, BusA, BusB, input Busy, Done, HI, LO);
  modport slave  (input Start, Op, BusA, BusB, output Busy, Done, HI, LO);
endinterface

// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative 32-cycle multiply/divide unit owning the HI/LO registers
module mult_div #(parameter int n = 32) (
  input logic       CLK,
  input logic       Reset_L,
  mult_div_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [5:0]     cnt;
  logic [2*n-1:0] acc;
  logic [n-1:0]   mcand;
  logic [n-1:0]   a_raw;
  logic           is_div, neg_res, neg_rem, div_zero;
  logic           busy_q, done_q;
  logic [n-1:0]   hi_q, lo_q;

  logic           is_signed, a_neg, b_neg;
  logic [n-1:0]   a_mag, b_mag;
  logic [n:0]     add_sum, shifted, diff;
  logic [2*n-1:0] acc_next, prod_fix;
  logic [n-1:0]   quo_fix, rem_fix;

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  always_comb begin
    is_signed = ~bus.Op[0];
    a_neg     = is_signed & bus.BusA[n-1];
    b_neg     = is_signed & bus.BusB[n-1];
    a_mag     = a_neg ? -bus.BusA : bus.BusA;
    b_mag     = b_neg ? -bus.BusB : bus.BusB;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add_sum = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, mcand} : {(n+1){1'b0}});
    shifted = {acc[2*n-1:n], acc[n-1]};
    diff    = shifted - {1'b0, mcand};
    if (is_div)
      acc_next = diff[n] ? {shifted[n-1:0], acc[n-2:0], 1'b0}
                         : {diff[n-1:0], acc[n-2:0], 1'b1};
    else
      acc_next = {add_sum, acc[n-1:1]};
    prod_fix = neg_res ? -acc_next : acc_next;
    quo_fix  = neg_res ? -acc_next[n-1:0] : acc_next[n-1:0];
    rem_fix  = neg_rem ? -acc_next[2*n-1:n] : acc_next[2*n-1:n];
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      acc      <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Op[2]) begin
            is_div   <= bus.Op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg & bus.Op[1];
            div_zero <= bus.Op[1] & (bus.BusB == '0);
            a_raw    <= bus.BusA;
            mcand    <= bus.Op[1] ? b_mag : a_mag;
            acc      <= {{n{1'b0}}, (bus.Op[1] ? a_mag : b_mag)};
            cnt      <= 6'd0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end else if (bus.Start && bus.Op[2:1] == 2'b10) begin
            if (bus.Op[0])
              lo_q <= bus.BusA;
            else
              hi_q <= bus.BusA;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            if (div_zero) begin
              hi_q <= a_raw;
              lo_q <= {n{1'b1}};
            end else if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*n-1:n];
              lo_q <= prod_fix[n-1:0];
            end
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - scoreboard bench for mult_div against an arithmetic reference model
module tb_mult_div;
  logic CLK = 1'b0;
  logic Reset_L = 1'b1;
  int passed = 0;
  int total = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  mult_div_if #(.n(32)) bus();
  mult_div #(.n(32)) dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: {HI, LO} straight from 64-bit integer arithmetic
  function automatic logic [63:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        ua = ua / ub;
        ub = {32'b0, a} % ub;
        return {ub[31:0], ua[31:0]};
      end
    endcase
  endfunction

  always @(negedge CLK) begin
    if (Reset_L && bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got Done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        check("result_hi", bus.HI, e[63:32]);
        check("result_lo", bus.LO, e[31:0]);
      end
    end
  end

  task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b, bit hold_mthi);
    int n;
    @(negedge CLK);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.BusA  = a;
    bus.BusB  = b;
    exp_q.push_back(ref_model(op, a, b));
    @(posedge CLK); #1;
    if (hold_mthi) begin
      bus.Op   = 3'b100;
      bus.BusA = 32'hDEADBEEF;
    end else begin
      bus.Start = 1'b0;
    end
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    bus.Start = 1'b0;
    check("busy_cycles", n, 32);
    check("done_pulse", {31'b0, bus.Done}, 32'd1);
    @(posedge CLK); #1;
    check("done_clear", {31'b0, bus.Done}, 32'd0);
    check("busy_idle", {31'b0, bus.Busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.Start = 1'b0;
    bus.Op    = 3'b000;
    bus.BusA  = '0;
    bus.BusB  = '0;
    #1 Reset_L = 1'b0;
    #1;
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_done", {31'b0, bus.Done}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    repeat (3) @(negedge CLK);
    Reset_L = 1'b1;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, 1'b0);
    run_op(3'd0, 32'h80000000, 32'h80000000, 1'b0);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(3'd3, 32'h00000064, 32'h00000007, 1'b0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'd3, 32'h00000064, 32'h00000000, 1'b0);
    run_op(3'd2, 32'hFFFFFF9C, 32'h00000000, 1'b0);

    @(negedge CLK);
    bus.Start = 1'b1;
    bus.Op    = 3'b100;
    bus.BusA  = 32'h12345678;
    @(posedge CLK); #1;
    check("mthi", bus.HI, 32'h12345678);
    @(negedge CLK);
    bus.Op   = 3'b101;
    bus.BusA = 32'h9ABCDEF0;
    @(posedge CLK); #1;
    check("mtlo", bus.LO, 32'h9ABCDEF0);
    check("mtlo_keeps_hi", bus.HI, 32'h12345678);
    @(negedge CLK);
    bus.Op   = 3'b110;
    bus.BusA = 32'h55555555;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    check("nop_hi", bus.HI, 32'h12345678);
    check("nop_lo", bus.LO, 32'h9ABCDEF0);
    check("mt_no_busy", {31'b0, bus.Busy}, 32'd0);

    run_op(3'd1, $urandom, $urandom, 1'b1);

    @(negedge CLK);
    bus.Start = 1'b1;
    bus.Op    = 3'b000;
    bus.BusA  = 32'd5;
    bus.BusB  = 32'd5;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.Busy}, 32'd0);
    check("abort_done", {31'b0, bus.Done}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    run_op(3'd3, 32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'b0);
    end

    repeat (2) @(negedge CLK);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_div.md
# mult_div

Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU. It takes the same BusA/BusB operands and computes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. It also performs MTHI/MTLO writes. HI/LO are read back by the datapath (MFHI/MFLO) through the writeback mux, so the processor stalls on Busy instead of stretching the ALU's combinational path.

## Interface
- n, 32, operand/result width; only 32 is supported and verified.
- CLK  input  1  rising-edge clock.
- Reset_L  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- BusA  input  n  multiplicand / dividend / MTHI-MTLO source.
- BusB  input  n  multiplier / divisor.
- Busy  output  1  high while an iteration sequence is running.
- Done  output  1  one-cycle pulse: HI/LO hold a new mult/div result.
- HI  output  n  HI register: product[63:32] or remainder.
- LO  output  n  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, CALC, DONE. A 6-bit iteration counter runs in CALC.
- IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU:
  - Capture the operands and sign flags.
  - Capture magnitudes: the absolute values for signed ops, the raw values for unsigned ops.
  - Clear the counter and go to CALC.
- IDLE, Start=1, Op=MTHI: at that edge HI<=BusA, stay in IDLE, no Done. MTLO likewise writes LO.
- IDLE, Start=1, Op=11x: no effect.
- CALC performs one iteration per clock, 32 iterations total.
  - Multiply: radix-2 shift-add on the magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on the magnitudes, producing a 32-bit quotient and remainder.
- The edge of the 32nd iteration:
  - Applies the sign fix-up.
  - Loads HI/LO.
  - Goes to DONE.
- Sign fix-up rules:
  - Signed product is negated (64-bit two's complement) if sign(A)≠sign(B).
  - Signed quotient is negated if sign(A)≠sign(B).
  - Signed remainder takes the sign of A.
  - All arithmetic is modulo 2^32 per half.
- Divide by zero (BusB=0 at capture) follows the normal 32-cycle path, with HI=BusA and LO=32'hFFFFFFFF, signed or unsigned.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DONE asserts Done for one cycle, then goes to IDLE at the next edge.
- Start in CALC or DONE is ignored; it is not queued.
- HI/LO are not modified until the final iteration edge; intermediate values stay in internal registers.

## Timing
- Reset_L low, asynchronously: state=IDLE, counter=0, Busy=0, Done=0, HI=0, LO=0.
  - Reset mid-CALC aborts the operation; no Done follows.
- Let edge E0 be the edge that captures Start in IDLE.
  - Busy=1 from after E0 through E32.
  - After E32: Busy=0, Done=1, and HI/LO hold the result.
  - After E33: Done=0 and state is IDLE.
  - The earliest next Start is captured at E34.
- Result latency is 32 cycles, issue-to-issue is 34 cycles, and latency is independent of operand values.
- MTHI/MTLO take effect at the capture edge; the value is visible on HI/LO one clock later.
- Busy and Done are registered outputs with no combinational path from inputs.
- HI/LO are visible to the datapath the cycle after Done rises.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Busy for 32 cycles, Done pulse after E32, HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 7 (0xFFFFFFFD, 0x00000007) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU 0x00000064 / 0x00000007 -> LO=0x0000000E, HI=0x00000002.
  - Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x00000064 / 0 -> HI=0x00000064, LO=0xFFFFFFFF after 32 cycles.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles -> HI/LO updated one edge each, Done never asserted.
  - Start a MULTU, then hold Start=1 with Op=MTHI 0xDEADBEEF while Busy -> request ignored, HI gets the product.
- Start MULT 5×5, drop Reset_L at cycle 10 of CALC -> Busy, Done, HI and LO go 0 immediately.
  - After release, DIVU 9/3 -> LO=3, HI=0 with normal 32-cycle latency.
